// File: rtl/proj_point_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : proj_point_plotter
// Description : Turns projected fixed-point vertices into framebuffer pixel
//               writes. Each vertex passes a two-stage pipeline (register,
//               then screen-space conversion + clip + linear address), is
//               queued in a small FIFO and drained to the framebuffer over a
//               req/ack port. A frame-clear command fills the whole screen
//               with a background colour once all queued points are written.
//
// Ports       : iClock      - clock
//               iReset      - asynchronous active-high reset
//               iVtxValid   - vertex inputs valid this cycle
//               i_X, i_Y    - signed fixed-point position (Y positive = up)
//               i_Exception - pipeline exception flag for this vertex
//               iColor      - point colour
//               iClear      - frame clear request pulse
//               iBgColor    - clear colour, sampled when the clear starts
//               oReady      - a vertex presented now will be accepted
//               oWrReq      - framebuffer write request
//               oWrAddr     - framebuffer write address
//               oWrData     - framebuffer write data
//               iWrAck      - framebuffer accepted the write this cycle
//               oClearDone  - one-cycle pulse when the clear completes
//               oDropCount  - saturating count of discarded vertices
//
// Revision    : 1.0 - initial release
// ============================================================================
module proj_point_plotter #(
  parameter int H_RES     = 160,
  parameter int V_RES     = 120,
  parameter int FRAC_BITS = 8,
  parameter int ADDR_W    = 15,
  parameter int COLOR_W   = 8,
  parameter int DEPTH     = 8
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iVtxValid,
  input  logic [15:0]        i_X,
  input  logic [15:0]        i_Y,
  input  logic               i_Exception,
  input  logic [COLOR_W-1:0] iColor,
  input  logic               iClear,
  input  logic [COLOR_W-1:0] iBgColor,
  output logic               oReady,
  output logic               oWrReq,
  output logic [ADDR_W-1:0]  oWrAddr,
  output logic [COLOR_W-1:0] oWrData,
  input  logic               iWrAck,
  output logic               oClearDone,
  output logic [7:0]         oDropCount
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_EW = ADDR_W + COLOR_W;

  localparam logic signed [17:0] c_H_S      = 18'(H_RES);
  localparam logic signed [17:0] c_V_S      = 18'(V_RES);
  localparam logic signed [17:0] c_HALF_H   = 18'(H_RES / 2);
  localparam logic signed [17:0] c_PY_OFF   = 18'(V_RES / 2 - 1);
  localparam logic [ADDR_W-1:0]  c_LAST_PIX = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [c_CW-1:0]    c_RDY_LIM  = c_CW'(DEPTH - 2);
  localparam logic [c_CW-1:0]    c_FULL     = c_CW'(DEPTH);
  localparam logic [c_CW-1:0]    c_ONE      = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic               r_rdy_en;     // holds oReady low until the first clock after reset
  logic               r_clr_pend;
  logic               r_wr_req;
  logic [ADDR_W-1:0]  r_wr_addr;    // doubles as the clear address counter
  logic [COLOR_W-1:0] r_wr_data;    // holds the latched background colour while clearing
  logic               r_clr_done;
  logic [7:0]         r_drop;

  // Stage 1: raw vertex
  logic               r_s1_v;
  logic [15:0]        r_s1_x;
  logic [15:0]        r_s1_y;
  logic               r_s1_exc;
  logic [COLOR_W-1:0] r_s1_col;

  // Stage 2: screen coordinates
  logic                    r_s2_v;
  logic signed [17:0]      r_s2_px;
  logic signed [17:0]      r_s2_py;
  logic                    r_s2_exc;
  logic [COLOR_W-1:0]      r_s2_col;

  // Point FIFO
  logic [c_EW-1:0]    r_mem [DEPTH];
  logic [c_PW-1:0]    r_wr_ptr;
  logic [c_PW-1:0]    r_rd_ptr;
  logic [c_CW-1:0]    r_count;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic               w_accept;
  logic               w_nr_drop;
  logic signed [17:0] w_x_ext;
  logic signed [17:0] w_y_ext;
  logic signed [17:0] w_px;
  logic signed [17:0] w_py;
  logic               w_s2_bad;
  logic               w_s2_ok;
  logic               w_s2_drop;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf_drop;
  logic [ADDR_W-1:0]  w_addr;
  logic [c_EW-1:0]    w_push_entry;
  logic [c_EW-1:0]    w_head;
  logic [c_EW-1:0]    w_head_nxt;
  logic [1:0]         w_drop_inc;
  logic [8:0]         w_drop_sum;

  assign oReady    = r_rdy_en && (r_count < c_RDY_LIM) && !r_clr_pend && (r_state != S_CLEAR);
  assign w_accept  = iVtxValid && oReady;
  assign w_nr_drop = iVtxValid && !oReady;

  // Arithmetic right shift on the sign-extended value floors toward -inf.
  assign w_x_ext = {{2{r_s1_x[15]}}, r_s1_x};
  assign w_y_ext = {{2{r_s1_y[15]}}, r_s1_y};
  assign w_px    = (w_x_ext >>> FRAC_BITS) + c_HALF_H;
  assign w_py    = c_PY_OFF - (w_y_ext >>> FRAC_BITS);

  assign w_s2_bad  = r_s2_exc || (r_s2_px < 0) || (r_s2_px >= c_H_S) ||
                     (r_s2_py < 0) || (r_s2_py >= c_V_S);
  assign w_s2_ok   = r_s2_v && !w_s2_bad;
  assign w_s2_drop = r_s2_v && w_s2_bad;
  assign w_addr    = ADDR_W'(r_s2_py * c_H_S + r_s2_px);

  // The FSM only sits in DRAIN with a request up, so an ack there is a pop.
  assign w_full       = (r_count == c_FULL);
  assign w_pop        = (r_state == S_DRAIN) && iWrAck;
  assign w_push       = w_s2_ok && (!w_full || w_pop);
  assign w_ovf_drop   = w_s2_ok && w_full && !w_pop;
  assign w_push_entry = {w_addr, r_s2_col};
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_nxt   = r_mem[r_rd_ptr + c_PW'(1)];

  assign w_drop_inc = 2'(w_nr_drop) + 2'(w_s2_drop) + 2'(w_ovf_drop);
  assign w_drop_sum = 9'(r_drop) + 9'(w_drop_inc);

  assign oWrReq     = r_wr_req;
  assign oWrAddr    = r_wr_addr;
  assign oWrData    = r_wr_data;
  assign oClearDone = r_clr_done;
  assign oDropCount = r_drop;

  // --------------------------------------------------------------------------
  // Vertex pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_rdy_en <= 1'b0;
      r_s1_v   <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_s1_exc <= 1'b0;
      r_s1_col <= '0;
      r_s2_v   <= 1'b0;
      r_s2_px  <= '0;
      r_s2_py  <= '0;
      r_s2_exc <= 1'b0;
      r_s2_col <= '0;
      r_drop   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_s1_v   <= w_accept;
      if (w_accept) begin
        r_s1_x   <= i_X;
        r_s1_y   <= i_Y;
        r_s1_exc <= i_Exception;
        r_s1_col <= iColor;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_px  <= w_px;
        r_s2_py  <= w_py;
        r_s2_exc <= r_s1_exc;
        r_s2_col <= r_s1_col;
      end
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Point FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge iClock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write-port FSM. The output registers always mirror the FIFO head while
  // draining; when the FIFO is empty (or down to its last entry) the entry
  // being pushed this cycle is forwarded directly so a request can follow a
  // push without an extra bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state    <= S_IDLE;
      r_wr_req   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_clr_done <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      // A clear already in progress is not restarted by another request.
      if (iClear && (r_state != S_CLEAR)) begin
        r_clr_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_wr_req               <= 1'b1;
            {r_wr_addr, r_wr_data} <= w_head;
            r_state                <= S_DRAIN;
          end else if (w_push) begin
            r_wr_req               <= 1'b1;
            {r_wr_addr, r_wr_data} <= w_push_entry;
            r_state                <= S_DRAIN;
          end else if (r_clr_pend && !r_s1_v && !r_s2_v) begin
            r_wr_req  <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= iBgColor;
            r_state   <= S_CLEAR;
          end
        end

        S_DRAIN: begin
          if (iWrAck) begin
            if (r_count > c_ONE) begin
              {r_wr_addr, r_wr_data} <= w_head_nxt;
            end else if (w_push) begin
              {r_wr_addr, r_wr_data} <= w_push_entry;
            end else begin
              r_wr_req <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end

        S_CLEAR: begin
          if (iWrAck) begin
            if (r_wr_addr == c_LAST_PIX) begin
              r_wr_req   <= 1'b0;
              r_clr_done <= 1'b1;
              r_clr_pend <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
          end
        end

        default: begin
          r_wr_req <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proj_point_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_proj_point_plotter
// Description : Self-checking bench for proj_point_plotter. Expected writes
//               go into a scoreboard queue as vertices are driven and are
//               popped by a monitor on every acknowledged write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proj_point_plotter;

  localparam int H_RES   = 160;
  localparam int V_RES   = 120;
  localparam int ADDR_W  = 15;
  localparam int COLOR_W = 8;
  localparam int NPIX    = H_RES * V_RES;

  logic               iClock      = 1'b0;
  logic               iReset      = 1'b1;
  logic               iVtxValid   = 1'b0;
  logic [15:0]        i_X         = '0;
  logic [15:0]        i_Y         = '0;
  logic               i_Exception = 1'b0;
  logic [COLOR_W-1:0] iColor      = '0;
  logic               iClear      = 1'b0;
  logic [COLOR_W-1:0] iBgColor    = 8'hA5;
  logic               iWrAck      = 1'b0;
  logic               oReady;
  logic               oWrReq;
  logic [ADDR_W-1:0]  oWrAddr;
  logic [COLOR_W-1:0] oWrData;
  logic               oClearDone;
  logic [7:0]         oDropCount;

  always #5 iClock = ~iClock;

  proj_point_plotter #(
    .H_RES(H_RES), .V_RES(V_RES), .FRAC_BITS(8),
    .ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .DEPTH(8)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iVtxValid(iVtxValid),
    .i_X(i_X), .i_Y(i_Y), .i_Exception(i_Exception), .iColor(iColor),
    .iClear(iClear), .iBgColor(iBgColor), .oReady(oReady),
    .oWrReq(oWrReq), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .iWrAck(iWrAck), .oClearDone(oClearDone), .oDropCount(oDropCount)
  );

  int total = 0;
  int bad = 0;
  int clear_pulses = 0;
  int exp_drops = 0;

  typedef struct {
    logic [ADDR_W-1:0]  a;
    logic [COLOR_W-1:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [15:0]        x;
    logic [15:0]        y;
    logic               exc;
    logic [COLOR_W-1:0] col;
    logic               ok;
    logic [ADDR_W-1:0]  addr;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [COLOR_W-1:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sbq.push_back(e);
  endtask

  task automatic set_vtx(input logic [15:0] x, input logic [15:0] y,
                         input logic exc, input logic [COLOR_W-1:0] col);
    iVtxValid   = 1'b1;
    i_X         = x;
    i_Y         = y;
    i_Exception = exc;
    iColor      = col;
  endtask

  // Write monitor: every acknowledged request must match the scoreboard head.
  always @(negedge iClock) begin : mon
    exp_t e;
    if (!iReset) begin
      if (oClearDone) clear_pulses++;
      if (oWrReq && iWrAck) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr=%0d data=0x%0h, no write expected", oWrAddr, oWrData);
        end else begin
          e = sbq.pop_front();
          chk("write_addr_data", {9'd0, oWrAddr, oWrData}, {9'd0, e.a, e.d});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  cnt;
    bit  done;

    vt[0]  = '{16'h0000, 16'h0000, 1'b0, 8'h3C, 1'b1, 15'd9520};
    vt[1]  = '{16'h0A00, 16'hFB00, 1'b0, 8'h5A, 1'b1, 15'd10330};
    vt[2]  = '{16'hB000, 16'hC400, 1'b0, 8'h11, 1'b1, 15'd19040};
    vt[3]  = '{16'h5000, 16'h0000, 1'b0, 8'h22, 1'b0, 15'd0};
    vt[4]  = '{16'h0000, 16'h3C00, 1'b0, 8'h33, 1'b0, 15'd0};
    vt[5]  = '{16'h0000, 16'h0000, 1'b1, 8'h44, 1'b0, 15'd0};
    vt[6]  = '{16'h4F00, 16'hC500, 1'b0, 8'h55, 1'b1, 15'd19039};
    vt[7]  = '{16'hFF80, 16'h0080, 1'b0, 8'h66, 1'b1, 15'd9519};
    vt[8]  = '{16'hB000, 16'h3B00, 1'b0, 8'h77, 1'b1, 15'd0};
    vt[9]  = '{16'hAF00, 16'h0000, 1'b0, 8'h88, 1'b0, 15'd0};
    vt[10] = '{16'h4FFF, 16'h3BFF, 1'b0, 8'h99, 1'b1, 15'd159};
    vt[11] = '{16'h0000, 16'hC3FF, 1'b0, 8'hAA, 1'b0, 15'd0};

    // ---------------- reset values ----------------
    #12;
    chk("rst_ready",     32'(oReady),     32'd0);
    chk("rst_wrreq",     32'(oWrReq),     32'd0);
    chk("rst_wraddr",    32'(oWrAddr),    32'd0);
    chk("rst_wrdata",    32'(oWrData),    32'd0);
    chk("rst_cleardone", 32'(oClearDone), 32'd0);
    chk("rst_dropcount", 32'(oDropCount), 32'd0);
    #10 iReset = 1'b0;
    @(negedge iClock);
    chk("ready_after_rst", 32'(oReady), 32'd1);

    // ---------------- single point, request timing ----------------
    iWrAck = 1'b1;
    @(posedge iClock); #1;
    set_vtx(vt[0].x, vt[0].y, vt[0].exc, vt[0].col);
    push_exp(vt[0].addr, vt[0].col);
    @(negedge iClock);
    chk("first_ready", 32'(oReady), 32'd1);
    @(posedge iClock); #1;
    iVtxValid = 1'b0;
    @(negedge iClock);
    chk("req_n1", 32'(oWrReq), 32'd0);
    @(negedge iClock);
    chk("req_n2", 32'(oWrReq), 32'd0);
    @(negedge iClock);
    chk("req_n3", 32'(oWrReq), 32'd1);
    chk("addr_n3", 32'(oWrAddr), 32'd9520);
    @(negedge iClock);
    chk("req_n4", 32'(oWrReq), 32'd0);

    // ---------------- table vectors, back to back, ack high ----------------
    for (int i = 0; i < 12; i++) begin
      @(posedge iClock); #1;
      set_vtx(vt[i].x, vt[i].y, vt[i].exc, vt[i].col);
      @(negedge iClock);
      chk("tbl_ready", 32'(oReady), 32'd1);
      if (vt[i].ok) push_exp(vt[i].addr, vt[i].col);
      else          exp_drops++;
    end
    @(posedge iClock); #1;
    iVtxValid = 1'b0;
    repeat (8) @(negedge iClock);
    chk("tbl_all_written", 32'(sbq.size()), 32'd0);
    chk("tbl_dropcount", 32'(oDropCount), 32'(exp_drops));

    // ---------------- backpressure burst ----------------
    @(posedge iClock); #1;
    iWrAck = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) begin
        @(posedge iClock); #1;
      end
      set_vtx(16'(k * 256), 16'h0000, 1'b0, 8'(8'h80 + k));
      @(negedge iClock);
      chk("burst_ready", 32'(oReady), (k < 8) ? 32'd1 : 32'd0);
      if (k < 8) push_exp(15'(9520 + k), 8'(8'h80 + k));
      else       exp_drops++;
    end
    @(posedge iClock); #1;
    iVtxValid = 1'b0;
    repeat (4) begin
      @(negedge iClock);
      chk("burst_hold_req",  32'(oWrReq),  32'd1);
      chk("burst_hold_addr", 32'(oWrAddr), 32'd9520);
      chk("burst_hold_data", 32'(oWrData), 32'h80);
    end
    chk("burst_dropcount", 32'(oDropCount), 32'(exp_drops));
    chk("burst_full_notready", 32'(oReady), 32'd0);
    @(posedge iClock); #1;
    iWrAck = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge iClock);
      n++;
    end
    chk("burst_drain_timeout", 32'(sbq.size()), 32'd0);
    @(negedge iClock);
    chk("burst_ready_again", 32'(oReady), 32'd1);
    chk("burst_req_low", 32'(oWrReq), 32'd0);

    // ---------------- frame clear behind two queued points ----------------
    @(posedge iClock); #1;
    iWrAck = 1'b0;
    set_vtx(16'h1400, 16'h0000, 1'b0, 8'hC1);
    push_exp(15'd9540, 8'hC1);
    @(posedge iClock); #1;
    set_vtx(16'h1500, 16'h0000, 1'b0, 8'hC2);
    push_exp(15'd9541, 8'hC2);
    @(posedge iClock); #1;
    iVtxValid = 1'b0;
    iClear    = 1'b1;
    @(posedge iClock); #1;
    iClear = 1'b0;
    @(negedge iClock);
    chk("clear_pending_notready", 32'(oReady), 32'd0);
    for (int a = 0; a < NPIX; a++) push_exp(15'(a), 8'hA5);
    @(posedge iClock); #1;
    iWrAck = 1'b1;
    n = 0;
    cnt = 0;
    done = 1'b0;
    while (!done && n < NPIX + 100) begin
      @(negedge iClock);
      n++;
      if (oClearDone) done = 1'b1;
      else if (oReady) cnt++;
      // A second clear request mid-clear must not restart it.
      if (n == 200) iClear = 1'b1;
      if (n == 201) iClear = 1'b0;
    end
    chk("clear_done_timeout", 32'(done), 32'd1);
    chk("clear_all_written", 32'(sbq.size()), 32'd0);
    chk("clear_ready_low_cycles", 32'(cnt), 32'd0);
    chk("clear_done_req_low", 32'(oWrReq), 32'd0);
    chk("clear_done_ready", 32'(oReady), 32'd1);
    cnt = 0;
    repeat (6) begin
      @(negedge iClock);
      if (oWrReq) cnt++;
    end
    chk("no_restart_reqs", 32'(cnt), 32'd0);
    chk("clear_pulse_count", 32'(clear_pulses), 32'd1);

    // ---------------- reset in the middle of a clear ----------------
    @(posedge iClock); #1;
    iWrAck = 1'b0;
    iClear = 1'b1;
    @(posedge iClock); #1;
    iClear = 1'b0;
    n = 0;
    while (!oWrReq && n < 10) begin
      @(negedge iClock);
      n++;
    end
    chk("midclear_req_seen", 32'(oWrReq), 32'd1);
    #2;
    iReset = 1'b1;
    #1;
    chk("async_rst_req",   32'(oWrReq),     32'd0);
    chk("async_rst_drops", 32'(oDropCount), 32'd0);
    chk("async_rst_ready", 32'(oReady),     32'd0);
    chk("async_rst_done",  32'(oClearDone), 32'd0);
    chk("async_rst_addr",  32'(oWrAddr),    32'd0);
    exp_drops = 0;
    @(posedge iClock);
    @(negedge iClock); #1;
    iReset = 1'b0;
    iWrAck = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge iClock);
      if (oWrReq || oClearDone) cnt++;
    end
    chk("post_rst_idle", 32'(cnt), 32'd0);
    chk("post_rst_pulses", 32'(clear_pulses), 32'd1);
    chk("post_rst_ready", 32'(oReady), 32'd1);
    @(posedge iClock); #1;
    set_vtx(vt[1].x, vt[1].y, vt[1].exc, vt[1].col);
    push_exp(vt[1].addr, vt[1].col);
    @(posedge iClock); #1;
    iVtxValid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge iClock);
      n++;
    end
    chk("post_rst_write", 32'(sbq.size()), 32'd0);
    repeat (3) @(negedge iClock);
    chk("post_rst_dropcount", 32'(oDropCount), 32'(exp_drops));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
